// File: rtl/prewish5k_mask_arbiter.sv
// prewish5k_mask_arbiter
//   Round-robin arbiter sharing the mentor's single mask-load channel among NREQ
//   requesters. A grant issues a one-cycle strobe with the winner's mask, then a
//   one-cycle ack to the winner, then HOLDOFF+1 cycles of holdoff before the next
//   arbitration. A free-running alive counter drives a heartbeat output.
// Ports
//   CLK_I    system clock
//   RST_I    asynchronous active-high reset
//   REQ_I    level request per requester, held until its own ACK_O is seen
//   DAT_I    mask per requester, slice i = DAT_I[8*i+7:8*i]
//   ACK_O    one-hot one-cycle ack to the granted requester
//   GNT_O    index of the last granted requester
//   STB_O    one-cycle load strobe to the mentor
//   DAT_O    mask to the mentor, stable from strobe until next grant
//   o_alive  MSB of the alive counter
module prewish5k_mask_arbiter #(
   parameter int unsigned NREQ       = 4,
   parameter int unsigned HOLDOFF    = 16,
   parameter int unsigned HOLD_BITS  = 8,
   parameter int unsigned ALIVE_BITS = 22
) (
   input  logic                CLK_I,
   input  logic                RST_I,
   input  logic [NREQ-1:0]     REQ_I,
   input  logic [8*NREQ-1:0]   DAT_I,
   output logic [NREQ-1:0]     ACK_O,
   output logic [2:0]          GNT_O,
   output logic                STB_O,
   output logic [7:0]          DAT_O,
   output logic                o_alive
);

   localparam logic [2:0]           LastInit = 3'(NREQ - 1);
   localparam logic [HOLD_BITS-1:0] HoldInit = HOLD_BITS'(HOLDOFF);

   typedef enum logic [1:0] {StIdle, StIssue, StHold} state_e;

   state_e                state_q, state_d;
   logic [2:0]            last_q, last_d;
   logic [2:0]            gnt_q, gnt_d;
   logic [HOLD_BITS-1:0]  hold_q, hold_d;
   logic [ALIVE_BITS-1:0] alive_q;
   logic                  stb_q, stb_d;
   logic [NREQ-1:0]       ack_q, ack_d;
   logic [7:0]            dat_q, dat_d;

   logic                  hi_found, lo_found, win_any;
   logic [2:0]            hi_idx, lo_idx, win_idx;
   logic [7:0]            dat_sel;
   logic [NREQ-1:0]       ack_onehot;

   // Round-robin pick: lowest requester above the last winner, otherwise the lowest
   // requester at or below it (wrap-around). Descending scan lets the lowest index win.
   always_comb begin
      hi_found = 1'b0;
      hi_idx   = '0;
      lo_found = 1'b0;
      lo_idx   = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (REQ_I[i]) begin
            if (i > int'(last_q)) begin
               hi_found = 1'b1;
               hi_idx   = 3'(i);
            end else begin
               lo_found = 1'b1;
               lo_idx   = 3'(i);
            end
         end
      end
      win_any = hi_found | lo_found;
      win_idx = hi_found ? hi_idx : lo_idx;
   end

   // Winner's mask slice and the ack vector for the stored winner.
   always_comb begin
      dat_sel    = '0;
      ack_onehot = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_idx == 3'(i)) begin
            dat_sel = DAT_I[8*i +: 8];
         end
         ack_onehot[i] = (last_q == 3'(i));
      end
   end

   // State register.
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (win_any) state_d = StIssue;
         StIssue: state_d = StHold;
         StHold:  if (hold_q == '0) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Output and datapath next values.
   always_comb begin
      stb_d  = 1'b0;
      ack_d  = '0;
      dat_d  = dat_q;
      gnt_d  = gnt_q;
      last_d = last_q;
      hold_d = hold_q;
      unique case (state_q)
         StIdle: begin
            if (win_any) begin
               stb_d  = 1'b1;
               dat_d  = dat_sel;
               gnt_d  = win_idx;
               last_d = win_idx;
            end
         end
         StIssue: begin
            ack_d  = ack_onehot;
            hold_d = HoldInit;
         end
         StHold: begin
            if (hold_q != '0) hold_d = hold_q - HOLD_BITS'(1);
         end
         default: ;
      endcase
   end

   // Registered outputs and datapath state.
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         stb_q   <= 1'b0;
         ack_q   <= '0;
         dat_q   <= '0;
         gnt_q   <= '0;
         last_q  <= LastInit;
         hold_q  <= '0;
         alive_q <= '0;
      end else begin
         stb_q   <= stb_d;
         ack_q   <= ack_d;
         dat_q   <= dat_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
         alive_q <= alive_q + ALIVE_BITS'(1);
      end
   end

   assign STB_O   = stb_q;
   assign ACK_O   = ack_q;
   assign DAT_O   = dat_q;
   assign GNT_O   = gnt_q;
   assign o_alive = alive_q[ALIVE_BITS-1];

endmodule

// File: tb/tb_prewish5k_mask_arbiter.sv
module tb_prewish5k_mask_arbiter;

   logic        CLK_I;
   logic        RST_I;
   logic [3:0]  REQ_I;
   logic [31:0] DAT_I;
   logic [3:0]  ACK_O;
   logic [2:0]  GNT_O;
   logic        STB_O;
   logic [7:0]  DAT_O;
   logic        o_alive;

   int vec_cnt = 0;
   int err_cnt = 0;

   prewish5k_mask_arbiter #(
      .NREQ       (4),
      .HOLDOFF    (2),
      .HOLD_BITS  (8),
      .ALIVE_BITS (4)
   ) dut (
      .CLK_I   (CLK_I),
      .RST_I   (RST_I),
      .REQ_I   (REQ_I),
      .DAT_I   (DAT_I),
      .ACK_O   (ACK_O),
      .GNT_O   (GNT_O),
      .STB_O   (STB_O),
      .DAT_O   (DAT_O),
      .o_alive (o_alive)
   );

   initial CLK_I = 1'b0;
   always #5 CLK_I = ~CLK_I;

   task automatic step();
      @(posedge CLK_I);
      #1;
   endtask

   task automatic do_reset();
      RST_I = 1'b1;
      REQ_I = '0;
      step();
      step();
      RST_I = 1'b0;
   endtask

   // Wait (bounded) for a strobe, check grant and mask, then check the ack and
   // drop the winner's request as a requester would on seeing its ack.
   task automatic grant_one(input int exp_g, input logic [7:0] exp_dat);
      bit seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         step();
         if (STB_O === 1'b1) seen = 1'b1;
      end
      vec_cnt++;
      if (!seen) begin
         err_cnt++;
         $display("FAIL grant_wait: no STB_O within 20 cycles, expected grant %0d", exp_g);
      end else begin
         vec_cnt++;
         if (GNT_O !== 3'(exp_g)) begin
            err_cnt++;
            $display("FAIL grant_gnt: GNT_O=%0d expected %0d", GNT_O, exp_g);
         end
         vec_cnt++;
         if (DAT_O !== exp_dat) begin
            err_cnt++;
            $display("FAIL grant_dat: DAT_O=%h expected %h", DAT_O, exp_dat);
         end
         vec_cnt++;
         if (ACK_O !== 4'b0000) begin
            err_cnt++;
            $display("FAIL grant_ack_with_stb: ACK_O=%b expected 0000", ACK_O);
         end
         step();
         vec_cnt++;
         if (ACK_O !== (4'b0001 << exp_g)) begin
            err_cnt++;
            $display("FAIL grant_ack: ACK_O=%b expected %b", ACK_O, 4'b0001 << exp_g);
         end
         vec_cnt++;
         if (STB_O !== 1'b0) begin
            err_cnt++;
            $display("FAIL grant_stb_len: STB_O=%b expected 0", STB_O);
         end
         REQ_I = REQ_I & ~(4'b0001 << exp_g);
      end
   endtask

   task automatic test_reset();
      RST_I = 1'b1;
      REQ_I = '0;
      DAT_I = 32'hDEAD_BEEF;
      step();
      step();
      vec_cnt++;
      if (STB_O !== 1'b0) begin err_cnt++; $display("FAIL reset_stb: %b expected 0", STB_O); end
      vec_cnt++;
      if (ACK_O !== 4'b0) begin err_cnt++; $display("FAIL reset_ack: %b expected 0000", ACK_O); end
      vec_cnt++;
      if (DAT_O !== 8'h00) begin err_cnt++; $display("FAIL reset_dat: %h expected 00", DAT_O); end
      vec_cnt++;
      if (GNT_O !== 3'd0) begin err_cnt++; $display("FAIL reset_gnt: %0d expected 0", GNT_O); end
      vec_cnt++;
      if (o_alive !== 1'b0) begin err_cnt++; $display("FAIL reset_alive: %b expected 0", o_alive); end
      RST_I = 1'b0;
   endtask

   task automatic test_single();
      do_reset();
      REQ_I = 4'b0010;
      DAT_I = 32'h44_33_A5_11;
      step();
      vec_cnt++;
      if (STB_O !== 1'b1) begin err_cnt++; $display("FAIL single_stb: %b expected 1", STB_O); end
      vec_cnt++;
      if (DAT_O !== 8'hA5) begin err_cnt++; $display("FAIL single_dat: %h expected a5", DAT_O); end
      vec_cnt++;
      if (GNT_O !== 3'd1) begin err_cnt++; $display("FAIL single_gnt: %0d expected 1", GNT_O); end
      vec_cnt++;
      if (ACK_O !== 4'b0) begin err_cnt++; $display("FAIL single_ack0: %b expected 0000", ACK_O); end
      step();
      vec_cnt++;
      if (STB_O !== 1'b0) begin err_cnt++; $display("FAIL single_stb1: %b expected 0", STB_O); end
      vec_cnt++;
      if (ACK_O !== 4'b0010) begin err_cnt++; $display("FAIL single_ack: %b expected 0010", ACK_O); end
      REQ_I = 4'b0000;
      DAT_I = 32'hFFFF_FFFF;
      step();
      vec_cnt++;
      if (ACK_O !== 4'b0) begin err_cnt++; $display("FAIL single_ack_len: %b expected 0000", ACK_O); end
      for (int c = 0; c < 4; c++) begin
         vec_cnt++;
         if (DAT_O !== 8'hA5) begin
            err_cnt++;
            $display("FAIL single_dat_hold: %h expected a5", DAT_O);
         end
         vec_cnt++;
         if (STB_O !== 1'b0) begin
            err_cnt++;
            $display("FAIL single_no_stb: %b expected 0", STB_O);
         end
         step();
      end
   endtask

   task automatic test_round_robin();
      int exp_seq [6] = '{0, 1, 2, 3, 0, 1};
      int n = 0;
      int last_cyc = 0;
      do_reset();
      DAT_I = 32'h04_03_02_01;
      REQ_I = 4'b1111;
      for (int c = 1; c <= 40 && n < 6; c++) begin
         step();
         vec_cnt++;
         if (STB_O === 1'b1 && ACK_O !== 4'b0) begin
            err_cnt++;
            $display("FAIL rr_excl: STB_O=1 with ACK_O=%b expected 0000", ACK_O);
         end
         if (STB_O === 1'b1) begin
            vec_cnt++;
            if (GNT_O !== 3'(exp_seq[n])) begin
               err_cnt++;
               $display("FAIL rr_gnt[%0d]: %0d expected %0d", n, GNT_O, exp_seq[n]);
            end
            if (n > 0) begin
               vec_cnt++;
               if (c - last_cyc != 5) begin
                  err_cnt++;
                  $display("FAIL rr_spacing[%0d]: %0d expected 5", n, c - last_cyc);
               end
            end
            last_cyc = c;
            n++;
         end
      end
      vec_cnt++;
      if (n != 6) begin
         err_cnt++;
         $display("FAIL rr_count: %0d strobes expected 6", n);
      end
      REQ_I = '0;
   endtask

   task automatic test_skip();
      do_reset();
      DAT_I = 32'hD3_C2_B1_A0;
      REQ_I = 4'b0001;
      grant_one(0, 8'hA0);
      step();
      step();
      step();
      REQ_I = 4'b0101;
      grant_one(2, 8'hC2);
      grant_one(0, 8'hA0);
   endtask

   task automatic test_async_reset();
      do_reset();
      DAT_I = 32'h44_33_22_11;
      REQ_I = 4'b0100;
      step();
      vec_cnt++;
      if (STB_O !== 1'b1 || GNT_O !== 3'd2) begin
         err_cnt++;
         $display("FAIL ar_pre: STB_O=%b GNT_O=%0d expected 1/2", STB_O, GNT_O);
      end
      #2 RST_I = 1'b1;
      #1;
      vec_cnt++;
      if (STB_O !== 1'b0) begin err_cnt++; $display("FAIL ar_stb: %b expected 0", STB_O); end
      vec_cnt++;
      if (ACK_O !== 4'b0) begin err_cnt++; $display("FAIL ar_ack: %b expected 0000", ACK_O); end
      vec_cnt++;
      if (GNT_O !== 3'd0) begin err_cnt++; $display("FAIL ar_gnt: %0d expected 0", GNT_O); end
      REQ_I = 4'b1111;
      step();
      RST_I = 1'b0;
      step();
      vec_cnt++;
      if (STB_O !== 1'b1 || GNT_O !== 3'd0) begin
         err_cnt++;
         $display("FAIL ar_first: STB_O=%b GNT_O=%0d expected 1/0", STB_O, GNT_O);
      end
      vec_cnt++;
      if (ACK_O !== 4'b0) begin err_cnt++; $display("FAIL ar_no_ack: %b expected 0000", ACK_O); end
      step();
      vec_cnt++;
      if (ACK_O !== 4'b0001) begin err_cnt++; $display("FAIL ar_ack0: %b expected 0001", ACK_O); end
      REQ_I = '0;
   endtask

   task automatic test_hold_lost();
      do_reset();
      DAT_I = 32'h88_77_66_55;
      REQ_I = 4'b0001;
      grant_one(0, 8'h55);
      REQ_I = 4'b1000;
      step();
      step();
      REQ_I = 4'b0000;
      for (int c = 0; c < 10; c++) begin
         vec_cnt++;
         if (STB_O !== 1'b0 || ACK_O !== 4'b0) begin
            err_cnt++;
            $display("FAIL hold_lost[%0d]: STB_O=%b ACK_O=%b expected 0/0000", c, STB_O, ACK_O);
         end
         step();
      end
   endtask

   task automatic test_alive();
      do_reset();
      vec_cnt++;
      if (o_alive !== 1'b0) begin err_cnt++; $display("FAIL alive_0: %b expected 0", o_alive); end
      for (int k = 1; k <= 40; k++) begin
         step();
         vec_cnt++;
         if (o_alive !== (((k % 16) >= 8) ? 1'b1 : 1'b0)) begin
            err_cnt++;
            $display("FAIL alive[%0d]: %b", k, o_alive);
         end
         vec_cnt++;
         if (STB_O !== 1'b0) begin
            err_cnt++;
            $display("FAIL alive_stb[%0d]: %b expected 0", k, STB_O);
         end
      end
   endtask

   initial begin
      RST_I = 1'b1;
      REQ_I = '0;
      DAT_I = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_skip();
      test_async_reset();
      test_hold_lost();
      test_alive();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
